// File: rtl/matrix_pkg.sv
// Shared types for the 16x16 LED matrix scanner.
package matrix_pkg;

  localparam int unsigned MATRIX_DIM = 16;
  localparam int unsigned ROW_W      = $clog2(MATRIX_DIM);

  typedef logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0] frame_t;
  typedef logic [MATRIX_DIM-1:0]                 line_t;
  typedef logic [ROW_W-1:0]                      row_idx_t;

  typedef enum logic {BLANK, DRIVE} scan_state_t;

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Frame/matrix-pin bundle between game logic and led_matrix_scanner.
// MATRIX_PWM_EN adds the brightness input.
interface led_matrix_scanner_if;
  import matrix_pkg::*;

  frame_t red;
  line_t  row_sel;
  line_t  col;
  logic   frame_done;
  logic   busy;

`ifdef MATRIX_PWM_EN
  logic [2:0] brightness;

  modport master (output red, output brightness,
                  input row_sel, input col, input frame_done, input busy);
  modport slave  (input red, input brightness,
                  output row_sel, output col, output frame_done, output busy);
`else
  modport master (output red,
                  input row_sel, input col, input frame_done, input busy);
  modport slave  (input red,
                  output row_sel, output col, output frame_done, output busy);
`endif

endinterface

// File: rtl/matrix_row_timer.sv
// Row/cycle counters and BLANK/DRIVE sequencing; the _c outputs describe the
// cycle that follows the coming clock edge. MATRIX_PWM_EN adds elapsed_c.
module matrix_row_timer
  import matrix_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output row_idx_t    row_c,
  output scan_state_t state_c,
  output logic        row_start_c,
  output logic        frame_wrap_c
`ifdef MATRIX_PWM_EN
  ,
  output logic [$clog2(CLK_DIV)-1:0] elapsed_c
`endif
);

  localparam int unsigned      CNT_W      = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= CLK_DIV || CLK_DIV > (1 << 20)) begin : g_bad_cfg
    $error("matrix_row_timer: need 1 <= BLANK_CYCLES < CLK_DIV <= 2^20");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  row_idx_t         row_q, row_d;
  scan_state_t      state_q, state_d;
  logic             run_q, run_d;

  // First edge out of reset starts row 0 at cycle 0 rather than advancing.
  always_comb begin
    cnt_d        = cnt_q;
    row_d        = row_q;
    state_d      = state_q;
    run_d        = 1'b1;
    row_start_c  = 1'b0;
    frame_wrap_c = 1'b0;
    if (!run_q) begin
      cnt_d       = '0;
      row_d       = '0;
      state_d     = BLANK;
      row_start_c = 1'b1;
    end else begin
      case (state_q)
        BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BLANK_LAST) state_d = DRIVE;
        end
        DRIVE: begin
          if (cnt_q == DIV_LAST) begin
            cnt_d        = '0;
            row_d        = row_q + ROW_W'(1);
            state_d      = BLANK;
            row_start_c  = 1'b1;
            frame_wrap_c = (row_q == ROW_W'(MATRIX_DIM - 1));
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = BLANK;
      endcase
    end
    row_c   = row_d;
    state_c = state_d;
`ifdef MATRIX_PWM_EN
    elapsed_c = cnt_d - CNT_W'(BLANK_CYCLES);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      row_q   <= '0;
      state_q <= BLANK;
      run_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed 16x16 LED matrix driver with per-frame snapshot and blanking.
// Optional MATRIX_PWM_EN adds a 3-bit brightness that trims the column window.
module led_matrix_scanner
  import matrix_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter logic        ROW_ON       = 1'b1,
  parameter logic        COL_ON       = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  led_matrix_scanner_if.slave bus
);

  row_idx_t    row_c;
  scan_state_t state_c;
  logic        row_start_c;
  logic        frame_wrap_c;

  frame_t frame_q, frame_d;
  line_t  row_sel_q, row_sel_d;
  line_t  col_q, col_d;
  logic   frame_done_q, frame_done_d;
  logic   busy_q, busy_d;
  logic   pwm_on;

`ifdef MATRIX_PWM_EN
  localparam int unsigned DRIVE_CYCLES = CLK_DIV - BLANK_CYCLES;
  logic [$clog2(CLK_DIV)-1:0] elapsed_c;
  logic [2:0]                 bright_q, bright_d;
`endif

  matrix_row_timer #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .row_c        (row_c),
    .state_c      (state_c),
    .row_start_c  (row_start_c),
    .frame_wrap_c (frame_wrap_c)
`ifdef MATRIX_PWM_EN
    ,
    .elapsed_c    (elapsed_c)
`endif
  );

  // Outputs are computed for the upcoming cycle; snapshot lands at row 0 start.
  always_comb begin
    frame_d      = frame_q;
    row_sel_d    = {MATRIX_DIM{~ROW_ON}};
    col_d        = {MATRIX_DIM{~COL_ON}};
    frame_done_d = frame_wrap_c;
    busy_d       = 1'b1;
    pwm_on       = 1'b1;
`ifdef MATRIX_PWM_EN
    bright_d = bright_q;
    pwm_on   = (32'(elapsed_c) << 3) < ((32'(bright_q) + 32'd1) * DRIVE_CYCLES);
`endif
    if (row_start_c && row_c == '0) begin
      frame_d = bus.red;
`ifdef MATRIX_PWM_EN
      bright_d = bus.brightness;
`endif
    end
    if (state_c == DRIVE) begin
      row_sel_d[row_c] = ROW_ON;
      if (pwm_on) col_d = frame_q[row_c] ^ {MATRIX_DIM{~COL_ON}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q      <= '0;
      row_sel_q    <= {MATRIX_DIM{~ROW_ON}};
      col_q        <= {MATRIX_DIM{~COL_ON}};
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef MATRIX_PWM_EN
      bright_q     <= '0;
`endif
    end else begin
      frame_q      <= frame_d;
      row_sel_q    <= row_sel_d;
      col_q        <= col_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
`ifdef MATRIX_PWM_EN
      bright_q     <= bright_d;
`endif
    end
  end

  assign bus.row_sel    = row_sel_q;
  assign bus.col        = col_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner (CLK_DIV=8, BLANK_CYCLES=2);
// build with MATRIX_PWM_EN defined to also exercise brightness.
module tb_led_matrix_scanner;
  import matrix_pkg::*;

  localparam int unsigned CLK_DIV = 8;
  localparam int unsigned BLANK   = 2;
  localparam int unsigned D       = CLK_DIV - BLANK;
  localparam int unsigned FRAME   = MATRIX_DIM * CLK_DIV;
`ifdef MATRIX_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  frame_t red_in = '0;
  int     bright_in = 7;
  frame_t snap;
  int     snap_b;
  int     tests_run = 0;
  int     tests_failed = 0;

  led_matrix_scanner_if bus ();
  assign bus.red = red_in;
`ifdef MATRIX_PWM_EN
  assign bus.brightness = 3'(bright_in);
`endif

  led_matrix_scanner #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK),
    .ROW_ON       (1'b1),
    .COL_ON       (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Expected outputs for cycle k after release, from row period arithmetic.
  function automatic void model(input int k, input frame_t f, input int b,
                                output line_t rs, output line_t cl, output logic fd);
    int row;
    int ph;
    int e;
    row = (k / CLK_DIV) % MATRIX_DIM;
    ph  = k % CLK_DIV;
    e   = ph - BLANK;
    rs  = '0;
    cl  = '0;
    fd  = (k > 0) && (k % FRAME == 0);
    if (ph >= BLANK) begin
      rs[row] = 1'b1;
      if (e * 8 < (b + 1) * D) cl = f[row];
    end
  endfunction

  function automatic frame_t diag_frame();
    frame_t f;
    for (int r = 0; r < MATRIX_DIM; r++) f[r] = 16'(1) << r;
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int r = 0; r < MATRIX_DIM; r++) f[r] = 16'($urandom);
    return f;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic hold_reset(input int n);
    rst = 1'b1;
    repeat (n) cyc();
  endtask

  task automatic snap_if_frame_start(input int k);
    if (k % FRAME == 0) begin
      snap   = red_in;
      snap_b = PWM ? bright_in : 7;
    end
  endtask

  task automatic test_reset();
    red_in = diag_frame();
    rst    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      tests_run++;
      if (bus.row_sel !== 16'h0 || bus.col !== 16'h0 || bus.frame_done !== 1'b0 || bus.busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset i=%0d row_sel=%h col=%h fd=%b busy=%b required 0000 0000 0 0",
                 i, bus.row_sel, bus.col, bus.frame_done, bus.busy);
      end
    end
  endtask

  task automatic test_diagonal_tearing();
    line_t ers, ecl;
    logic  efd;
    int    fd_count = 0;
    red_in    = diag_frame();
    bright_in = 7;
    rst       = 1'b0;
    for (int k = 0; k < 3 * FRAME + 16; k++) begin
      snap_if_frame_start(k);
      cyc();
      model(k, snap, snap_b, ers, ecl, efd);
      if (bus.frame_done === 1'b1) fd_count++;
      tests_run++;
      if (bus.row_sel !== ers) begin
        tests_failed++;
        $display("FAIL diag_row_sel k=%0d got %h exp %h", k, bus.row_sel, ers);
      end
      tests_run++;
      if (bus.col !== ecl) begin
        tests_failed++;
        $display("FAIL diag_col k=%0d got %h exp %h", k, bus.col, ecl);
      end
      tests_run++;
      if (bus.frame_done !== efd) begin
        tests_failed++;
        $display("FAIL diag_frame_done k=%0d got %b exp %b", k, bus.frame_done, efd);
      end
      tests_run++;
      if (bus.busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL diag_busy k=%0d got %b exp 1", k, bus.busy);
      end
      tests_run++;
      if ($countones(bus.row_sel) > 1) begin
        tests_failed++;
        $display("FAIL one_hot k=%0d row_sel=%h", k, bus.row_sel);
      end
      if (k == 39) red_in = '1;
    end
    tests_run++;
    if (fd_count !== 3) begin
      tests_failed++;
      $display("FAIL frame_done_count got %0d exp 3", fd_count);
    end
  endtask

  task automatic test_reset_mid_scan();
    line_t ers, ecl;
    logic  efd;
    hold_reset(2);
    red_in    = rand_frame();
    bright_in = 7;
    rst       = 1'b0;
    for (int k = 0; k < 60; k++) begin
      snap_if_frame_start(k);
      cyc();
      model(k, snap, snap_b, ers, ecl, efd);
      tests_run++;
      if (bus.row_sel !== ers || bus.col !== ecl) begin
        tests_failed++;
        $display("FAIL pre_reset k=%0d got %h/%h exp %h/%h", k, bus.row_sel, bus.col, ers, ecl);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      tests_run++;
      if (bus.row_sel !== 16'h0 || bus.col !== 16'h0 || bus.frame_done !== 1'b0 || bus.busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL mid_reset i=%0d row_sel=%h col=%h fd=%b busy=%b required 0000 0000 0 0",
                 i, bus.row_sel, bus.col, bus.frame_done, bus.busy);
      end
    end
    red_in = rand_frame();
    rst    = 1'b0;
    for (int k = 0; k < FRAME + 10; k++) begin
      snap_if_frame_start(k);
      cyc();
      model(k, snap, snap_b, ers, ecl, efd);
      tests_run++;
      if (bus.row_sel !== ers || bus.col !== ecl || bus.frame_done !== efd || bus.busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL restart k=%0d got %h/%h/%b/%b exp %h/%h/%b/1",
                 k, bus.row_sel, bus.col, bus.frame_done, bus.busy, ers, ecl, efd);
      end
    end
  endtask

  task automatic test_random();
    line_t ers, ecl;
    logic  efd;
    hold_reset(1);
    red_in    = rand_frame();
    bright_in = PWM ? int'($urandom_range(7, 0)) : 7;
    rst       = 1'b0;
    for (int k = 0; k < 3 * FRAME + 5; k++) begin
      snap_if_frame_start(k);
      cyc();
      model(k, snap, snap_b, ers, ecl, efd);
      tests_run++;
      if (bus.row_sel !== ers || bus.col !== ecl || bus.frame_done !== efd) begin
        tests_failed++;
        $display("FAIL random k=%0d b=%0d got %h/%h/%b exp %h/%h/%b",
                 k, snap_b, bus.row_sel, bus.col, bus.frame_done, ers, ecl, efd);
      end
      tests_run++;
      if ($countones(bus.row_sel) > 1) begin
        tests_failed++;
        $display("FAIL random_one_hot k=%0d row_sel=%h", k, bus.row_sel);
      end
      if ($urandom_range(9, 0) == 0) red_in = rand_frame();
      if (PWM && $urandom_range(19, 0) == 0) bright_in = int'($urandom_range(7, 0));
    end
  endtask

`ifdef MATRIX_PWM_EN
  task automatic test_pwm();
    line_t exp_rs, exp_col;
    int    ph;
    int    row;
    int    on_len;
    hold_reset(1);
    red_in    = '1;
    bright_in = 3;
    rst       = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      cyc();
      ph      = k % CLK_DIV;
      row     = (k / CLK_DIV) % MATRIX_DIM;
      on_len  = (k < FRAME) ? 3 : 6;
      exp_rs  = '0;
      exp_col = '0;
      if (ph >= BLANK) exp_rs[row] = 1'b1;
      if (ph >= BLANK && ph - BLANK < on_len) exp_col = 16'hFFFF;
      tests_run++;
      if (bus.row_sel !== exp_rs || bus.col !== exp_col) begin
        tests_failed++;
        $display("FAIL pwm k=%0d got %h/%h exp %h/%h", k, bus.row_sel, bus.col, exp_rs, exp_col);
      end
      if (k == FRAME - 1) bright_in = 7;
    end
  endtask
`endif

  initial begin
    snap   = '0;
    snap_b = 7;
    test_reset();
    test_diagonal_tearing();
    test_reset_mid_scan();
    test_random();
`ifdef MATRIX_PWM_EN
    test_pwm();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
